bc_scorer: RTL and testbench

- Sequential scoring engine for the Bulls & Cows game.
- Sits directly downstream of the game-control FSM's guess capture stage.
- On a start pulse it latches a secret and a guess, checks the guess for legality, then counts bulls and cows one digit per cycle.
- Returns the result with a one-cycle done pulse; the control FSM consumes this to choose between WIN and the next player's GUESS.

---
 rtl/bc_pkg.sv | 17 +
 rtl/bc_digit_match.sv | 27 ++
 rtl/bc_scorer.sv | 163 ++++++++++++++++
 tb/tb_bc_scorer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared types and defaults for the Bulls & Cows scoring engine.
package bc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VALIDATE = 2'd1,
        SCORE    = 2'd2,
        DONE     = 2'd3
    } bc_state_e;

    localparam int BC_DIGITS    = 4;
    localparam int BC_DW        = 4;
    localparam int BC_MAX_DIGIT = 9;

    localparam logic [3:0] NULL_DIGIT = 4'hF;

endpackage

// File: rtl/bc_digit_match.sv
// Compares one digit against every digit of a code, splitting hits into
// same-position and other-position matches.
module bc_digit_match
    import bc_pkg::*;
#(
    parameter int DIGITS = BC_DIGITS,
    parameter int DW     = BC_DW,
    parameter int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic [DW-1:0]        digit,
    input  logic [DIGITS*DW-1:0] code,
    input  logic [IW-1:0]        idx,
    output logic                 pos_hit,
    output logic                 other_hit
);

    // OR-reduce equality hits into the two position classes
    always_comb begin
        pos_hit   = 1'b0;
        other_hit = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            pos_hit   = pos_hit   | ((code[j*DW +: DW] == digit) & (IW'(j) == idx));
            other_hit = other_hit | ((code[j*DW +: DW] == digit) & (IW'(j) != idx));
        end
    end

endmodule

// File: rtl/bc_scorer.sv
// Sequential Bulls & Cows scorer: latches a secret/guess pair, validates the
// guess one digit per cycle, then counts bulls and cows one digit per cycle.
module bc_scorer
    import bc_pkg::*;
#(
    parameter int DIGITS    = BC_DIGITS,
    parameter int DW        = BC_DW,
    parameter int MAX_DIGIT = BC_MAX_DIGIT,
    localparam int CW       = $clog2(DIGITS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DIGITS*DW-1:0] secret,
    input  logic [DIGITS*DW-1:0] guess,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        bulls,
    output logic [CW-1:0]        cows,
    output logic                 win,
    output logic                 invalid
);

    localparam int            IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    bc_state_e            state_r;
    logic [IW-1:0]        idx_r;
    logic [DIGITS*DW-1:0] secret_r;
    logic [DIGITS*DW-1:0] guess_r;
    logic                 illegal_r;
    logic [CW-1:0]        bull_cnt_r;
    logic [CW-1:0]        cow_cnt_r;
    logic                 busy_r;
    logic                 done_r;
    logic [CW-1:0]        bulls_r;
    logic [CW-1:0]        cows_r;
    logic                 win_r;
    logic                 invalid_r;

    logic [DW-1:0]        digit_s;
    logic [DIGITS*DW-1:0] code_s;
    logic                 pos_hit_s;
    logic                 other_hit_s;
    logic                 bad_digit_s;

    // Select the current guess digit and the code it is matched against
    always_comb begin
        digit_s = DW'(NULL_DIGIT);
        code_s  = guess_r;
        case (state_r)
            VALIDATE: begin
                digit_s = guess_r[idx_r*DW +: DW];
                code_s  = guess_r;
            end
            SCORE: begin
                digit_s = guess_r[idx_r*DW +: DW];
                code_s  = secret_r;
            end
            default: begin
                digit_s = DW'(NULL_DIGIT);
                code_s  = guess_r;
            end
        endcase
    end

    bc_digit_match #(
        .DIGITS (DIGITS),
        .DW     (DW),
        .IW     (IW)
    ) u_match (
        .digit     (digit_s),
        .code      (code_s),
        .idx       (idx_r),
        .pos_hit   (pos_hit_s),
        .other_hit (other_hit_s)
    );

    // A repeat against any other position is enough: a pair j<idx was already
    // flagged when j was visited, so "j > idx" and "j != idx" give the same sticky flag.
    assign bad_digit_s = (int'(digit_s) > MAX_DIGIT) | other_hit_s;

    // Control FSM with working counters and registered result outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            idx_r      <= {IW{1'b0}};
            secret_r   <= {(DIGITS*DW){1'b0}};
            guess_r    <= {(DIGITS*DW){1'b0}};
            illegal_r  <= 1'b0;
            bull_cnt_r <= {CW{1'b0}};
            cow_cnt_r  <= {CW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bulls_r    <= {CW{1'b0}};
            cows_r     <= {CW{1'b0}};
            win_r      <= 1'b0;
            invalid_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    // busy_r still high here means done is showing; start is ignored
                    if (start && !busy_r) begin
                        secret_r   <= secret;
                        guess_r    <= guess;
                        bull_cnt_r <= {CW{1'b0}};
                        cow_cnt_r  <= {CW{1'b0}};
                        illegal_r  <= 1'b0;
                        idx_r      <= {IW{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= VALIDATE;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                VALIDATE: begin
                    illegal_r <= illegal_r | bad_digit_s;
                    if (idx_r == LAST_IDX) begin
                        idx_r   <= {IW{1'b0}};
                        state_r <= (illegal_r | bad_digit_s) ? DONE : SCORE;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                SCORE: begin
                    if (pos_hit_s) begin
                        bull_cnt_r <= bull_cnt_r + CW'(1);
                    end else if (other_hit_s) begin
                        cow_cnt_r <= cow_cnt_r + CW'(1);
                    end else begin
                        bull_cnt_r <= bull_cnt_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= DONE;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                DONE: begin
                    done_r    <= 1'b1;
                    bulls_r   <= illegal_r ? {CW{1'b0}} : bull_cnt_r;
                    cows_r    <= illegal_r ? {CW{1'b0}} : cow_cnt_r;
                    invalid_r <= illegal_r;
                    win_r     <= (bull_cnt_r == CW'(DIGITS)) & ~illegal_r;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bulls   = bulls_r;
    assign cows    = cows_r;
    assign win     = win_r;
    assign invalid = invalid_r;

endmodule

// File: tb/tb_bc_scorer.sv
// Self-checking bench for bc_scorer: directed vector table, corner sequences
// and randomized runs against a behavioural scoring model.
module tb_bc_scorer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] secret = 16'h0000;
    logic [15:0] guess = 16'h0000;
    logic        busy, done, win, invalid;
    logic [2:0]  bulls, cows;

    int total = 0;
    int bad = 0;

    bc_scorer dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .secret  (secret),
        .guess   (guess),
        .busy    (busy),
        .done    (done),
        .bulls   (bulls),
        .cows    (cows),
        .win     (win),
        .invalid (invalid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] s;
        logic [15:0] g;
        int b;
        int c;
        int w;
        int inv;
        int lat;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference scoring straight from the game rules
    function automatic void model(input logic [15:0] s, input logic [15:0] g,
                                  output int b, output int c, output int w,
                                  output int inv, output int lat);
        int sd[4];
        int gd[4];
        b = 0; c = 0; inv = 0;
        for (int i = 0; i < 4; i++) begin
            sd[i] = int'(s[i*4 +: 4]);
            gd[i] = int'(g[i*4 +: 4]);
        end
        for (int i = 0; i < 4; i++) begin
            if (gd[i] > 9) inv = 1;
            for (int j = 0; j < 4; j++)
                if (j != i && gd[i] == gd[j]) inv = 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (gd[i] == sd[i]) b++;
            else begin
                int found = 0;
                for (int j = 0; j < 4; j++)
                    if (j != i && gd[i] == sd[j]) found = 1;
                c += found;
            end
        end
        w = (inv == 0 && b == 4) ? 1 : 0;
        if (inv != 0) begin
            b = 0; c = 0; lat = 5;
        end else begin
            lat = 9;
        end
    endfunction

    function automatic logic [15:0] rand_code(input bit distinct, input bit allow_hex);
        logic [15:0] v;
        logic [3:0] d;
        v = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            d = 4'($urandom_range(0, 9));
            if (distinct) begin
                for (int t = 0; t < 40; t++) begin
                    bit rep;
                    rep = 1'b0;
                    for (int j = 0; j < i; j++)
                        if (v[j*4 +: 4] == d) rep = 1'b1;
                    if (!rep) break;
                    d = 4'($urandom_range(0, 9));
                end
            end
            if (allow_hex && $urandom_range(0, 7) == 0) d = 4'($urandom_range(10, 15));
            v[i*4 +: 4] = d;
        end
        return v;
    endfunction

    // One request: start sampled at edge E0, then 14 edges observed.
    // inject_at re-raises start at edge E<inject_at>; mid_* sample results at E3.
    task automatic run(input logic [15:0] s, input logic [15:0] g, input int inject_at,
                       output int lat, output int ndone, output int busy0,
                       output int mid_b, output int mid_c);
        @(negedge clock);
        secret = s;
        guess  = g;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        secret = 16'($urandom);
        guess  = 16'($urandom);
        busy0 = int'(busy);
        lat = 0; ndone = 0; mid_b = -1; mid_c = -1;
        for (int k = 1; k <= 14; k++) begin
            start = (k == inject_at) ? 1'b1 : 1'b0;
            @(negedge clock);
            if (done) begin
                ndone++;
                lat = k;
            end
            if (k == 3) begin
                mid_b = int'(bulls);
                mid_c = int'(cows);
            end
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [15:0] s, input logic [15:0] g,
                             input int eb, input int ec, input int ew, input int einv,
                             input int elat, input int inject_at);
        int lat, nd, b0, mb, mc;
        run(s, g, inject_at, lat, nd, b0, mb, mc);
        chk({tag, ".busy"}, b0, 1);
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".ndone"}, nd, 1);
        chk({tag, ".bulls"}, int'(bulls), eb);
        chk({tag, ".cows"}, int'(cows), ec);
        chk({tag, ".win"}, int'(win), ew);
        chk({tag, ".invalid"}, int'(invalid), einv);
        chk({tag, ".idle_busy"}, int'(busy), 0);
    endtask

    initial begin
        int lat, nd, b0, mb, mc, eb, ec, ew, einv, elat;
        logic [15:0] rs, rg;

        tbl[0]  = '{16'h1234, 16'h1234, 4, 0, 1, 0, 9};
        tbl[1]  = '{16'h1234, 16'h4321, 0, 4, 0, 0, 9};
        tbl[2]  = '{16'h1234, 16'h1243, 2, 2, 0, 0, 9};
        tbl[3]  = '{16'h1234, 16'h5678, 0, 0, 0, 0, 9};
        tbl[4]  = '{16'h1234, 16'h1123, 0, 0, 0, 1, 5};
        tbl[5]  = '{16'h1234, 16'h12A4, 0, 0, 0, 1, 5};
        tbl[6]  = '{16'h1234, 16'h1235, 3, 0, 0, 0, 9};
        tbl[7]  = '{16'h1234, 16'h2135, 1, 2, 0, 0, 9};
        tbl[8]  = '{16'h0987, 16'h9870, 0, 4, 0, 0, 9};
        tbl[9]  = '{16'h1123, 16'h3014, 0, 2, 0, 0, 9};
        tbl[10] = '{16'h9876, 16'h6789, 0, 4, 0, 0, 9};

        #1;
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.bulls", int'(bulls), 0);
        chk("rst.cows", int'(cows), 0);
        chk("rst.win", int'(win), 0);
        chk("rst.invalid", int'(invalid), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 11; i++)
            check_run($sformatf("tbl%0d", i), tbl[i].s, tbl[i].g,
                      tbl[i].b, tbl[i].c, tbl[i].w, tbl[i].inv, tbl[i].lat, 0);

        // Results hold through a new request until its DONE
        check_run("hold_a", 16'h1234, 16'h1243, 2, 2, 0, 0, 9, 0);
        run(16'h1234, 16'h5678, 0, lat, nd, b0, mb, mc);
        chk("hold.mid_bulls", mb, 2);
        chk("hold.mid_cows", mc, 2);
        chk("hold.new_bulls", int'(bulls), 0);
        chk("hold.new_cows", int'(cows), 0);

        // Second start three cycles into a run is ignored
        check_run("restart", 16'h1234, 16'h4321, 0, 4, 0, 0, 9, 3);

        // Reset during SCORE discards the run
        check_run("pre_rst", 16'h1234, 16'h1234, 4, 0, 1, 0, 9, 0);
        @(negedge clock);
        secret = 16'h1234;
        guess  = 16'h1243;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.bulls", int'(bulls), 0);
        chk("midrst.cows", int'(cows), 0);
        chk("midrst.win", int'(win), 0);
        chk("midrst.invalid", int'(invalid), 0);
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (done) nd++;
        end
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (done) nd++;
        end
        chk("midrst.no_done", nd, 0);
        check_run("post_rst", 16'h1234, 16'h1243, 2, 2, 0, 0, 9, 0);

        // Randomized runs against the reference model
        for (int n = 0; n < 48; n++) begin
            rs = rand_code(($urandom_range(0, 3) != 0), 1'b0);
            case (n % 3)
                0:       rg = rand_code(1'b1, 1'b0);
                1:       rg = rand_code(1'b1, 1'b1);
                default: rg = rand_code(1'b0, 1'b1);
            endcase
            if (n % 8 == 7) rg = {rs[3:0], rs[15:4]};
            model(rs, rg, eb, ec, ew, einv, elat);
            check_run($sformatf("rnd%0d_%h_%h", n, rs, rg), rs, rg, eb, ec, ew, einv, elat, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
